bch_stim_gen: RTL and testbench

Upstream stimulus source for the BCH encode/decode checker. It produces pseudo-random data words and error vectors with an exact, runtime-selected Hamming weight, and presents them on a start/ready handshake. Its outputs feed the checker's data_in, error and encode_start inputs directly. Generation is fully deterministic from SEED, so every failure reproduces.

---
 rtl/bch_stim_pkg.sv | 24 ++
 rtl/bch_stim_gen_if.sv | 25 ++
 rtl/bch_stim_lfsr.sv | 27 ++
 rtl/bch_stim_gen.sv | 151 +++++++++++++++
 tb/tb_bch_stim_gen.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/bch_stim_pkg.sv
// Shared types and helpers for the BCH stimulus generator: FSM states,
// LFSR geometry and the Galois step function.
package bch_stim_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PLACE,
        PRESENT
    } state_t;

    localparam int unsigned LFSR_W = 32;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

    // One right-shifting Galois step; the taps fold in when bit 0 falls out.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic int unsigned fill_cycles(input int unsigned data_bits);
        return (data_bits + LFSR_W - 1) / LFSR_W;
    endfunction

endpackage

// File: rtl/bch_stim_gen_if.sv
// Word handshake between the stimulus generator (master) and the BCH
// checker (slave).
interface bch_stim_gen_if #(
    parameter int unsigned DATA_BITS = 64,
    parameter int unsigned CODE_BITS = 78,
    parameter int unsigned WEIGHT_W  = 4
);
    logic                 ready;
    logic                 start_out;
    logic [DATA_BITS-1:0] data_out;
    logic [CODE_BITS-1:0] error_out;
    logic [WEIGHT_W-1:0]  weight_out;
    logic [31:0]          words_sent;
    logic                 done;

    modport master (
        input  ready,
        output start_out, data_out, error_out, weight_out, words_sent, done
    );

    modport slave (
        output ready,
        input  start_out, data_out, error_out, weight_out, words_sent, done
    );
endinterface

// File: rtl/bch_stim_lfsr.sv
// Seeded 32-bit Galois LFSR with an advance enable; exposes the state it
// will move to next so callers can consume it in the same cycle.
module bch_stim_lfsr
    import bch_stim_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 32'h0000_0001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    output logic [LFSR_W-1:0] next_c
);
    // An all-zero seed would lock the register up, so it becomes 1.
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

    logic [LFSR_W-1:0] lfsr_q;

    assign next_c = lfsr_step(lfsr_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED_EFF;
        end else if (advance) begin
            lfsr_q <= next_c;
        end
    end
endmodule

// File: rtl/bch_stim_gen.sv
// Pseudo-random data word + exact-weight error vector source for the BCH
// checker. Build macro BCH_STIM_BURST_EN selects contiguous burst errors.
module bch_stim_gen
    import bch_stim_pkg::*;
#(
    parameter int unsigned DATA_BITS = 64,
    parameter int unsigned CODE_BITS = 78,
    parameter int unsigned WEIGHT_W  = 4,
    parameter logic [31:0] SEED      = 32'h0000_0001,
    parameter int unsigned NUM_WORDS = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [WEIGHT_W-1:0] err_weight,
    bch_stim_gen_if.master      bus
);
    localparam int unsigned F      = fill_cycles(DATA_BITS);
    localparam int unsigned P      = (CODE_BITS > 1) ? $clog2(CODE_BITS) : 1;
    localparam int unsigned FCNT_W = (F > 1) ? $clog2(F) : 1;
    localparam logic [FCNT_W-1:0] F_LAST = FCNT_W'(F - 1);

    state_t               state;
    logic [FCNT_W-1:0]    fill_cnt;
    logic [WEIGHT_W-1:0]  w;
    logic [WEIGHT_W-1:0]  placed;
    logic [DATA_BITS-1:0] data_sr;
    logic [CODE_BITS-1:0] error_sr;
    logic                 start_q;
    logic [WEIGHT_W-1:0]  weight_q;
    logic [31:0]          words_q;
    logic                 done_q;

    logic [LFSR_W-1:0]    lfsr_next_c;
    logic                 advance_c;
    logic [P-1:0]         pos_c;
    logic                 accept_c;
    logic                 last_c;
    logic [CODE_BITS-1:0] set_mask_c;
    logic [WEIGHT_W-1:0]  w_clamp_c;

    assign advance_c = (state == FILL) || (state == PLACE);

    bch_stim_lfsr #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (advance_c),
        .next_c  (lfsr_next_c)
    );

    assign w_clamp_c = (32'(err_weight) > CODE_BITS) ? WEIGHT_W'(CODE_BITS) : err_weight;
    assign pos_c     = lfsr_next_c[P-1:0];

    // Candidate evaluation for the current PLACE draw.
    always_comb begin
        set_mask_c = '0;
        accept_c   = 1'b0;
        last_c     = 1'b0;
`ifdef BCH_STIM_BURST_EN
        for (int unsigned i = 0; i < CODE_BITS; i++) begin
            set_mask_c[i] = (i >= 32'(pos_c)) && (i < 32'(pos_c) + 32'(w));
        end
        accept_c = (placed == '0) && ((32'(pos_c) + 32'(w)) <= CODE_BITS);
        last_c   = 1'b1;
`else
        set_mask_c = CODE_BITS'(1) << pos_c;
        accept_c   = (32'(pos_c) < CODE_BITS) && ((error_sr & set_mask_c) == '0);
        last_c     = (WEIGHT_W'(placed + 1'b1) == w);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fill_cnt <= '0;
            w        <= '0;
            placed   <= '0;
            data_sr  <= '0;
            error_sr <= '0;
            start_q  <= 1'b0;
            weight_q <= '0;
            words_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    data_sr  <= '0;
                    error_sr <= '0;
                    fill_cnt <= '0;
                    placed   <= '0;
                    if (enable && !done_q) begin
                        w     <= w_clamp_c;
                        state <= FILL;
                    end
                end
                FILL: begin
                    data_sr  <= DATA_BITS'({data_sr, lfsr_next_c});
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt == F_LAST) begin
                        if (w != '0) begin
                            state <= PLACE;
                        end else begin
                            state    <= PRESENT;
                            start_q  <= 1'b1;
                            weight_q <= w;
                        end
                    end
                end
                PLACE: begin
                    if (accept_c) begin
                        error_sr <= error_sr | set_mask_c;
                        placed   <= placed + 1'b1;
                        if (last_c) begin
                            state    <= PRESENT;
                            start_q  <= 1'b1;
                            weight_q <= w;
                        end
                    end
                end
                PRESENT: begin
                    if (bus.ready) begin
                        start_q <= 1'b0;
                        words_q <= words_q + 32'd1;
                        if ((NUM_WORDS != 0) && ((words_q + 32'd1) == 32'(NUM_WORDS))) begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end else if (enable) begin
                            // Skip IDLE: restart generation straight from the accept.
                            w        <= w_clamp_c;
                            data_sr  <= '0;
                            error_sr <= '0;
                            fill_cnt <= '0;
                            placed   <= '0;
                            state    <= FILL;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.start_out  = start_q;
    assign bus.data_out   = data_sr;
    assign bus.error_out  = error_sr;
    assign bus.weight_out = weight_q;
    assign bus.words_sent = words_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_bch_stim_gen.sv
// Directed bench for bch_stim_gen: three instances cover the default
// geometry (SEED=0), a narrow code word (CODE_BITS=8) and NUM_WORDS=3.
module tb_bch_stim_gen;

    localparam logic [63:0] WORD1 = 64'h80200003_C0300002;
    localparam logic [63:0] WORD2 = 64'h60180001_B02C0003;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       rst_a = 1'b1, en_a = 1'b0;
    logic [3:0] ew_a  = 4'd0;
    logic       rst_b = 1'b1, en_b = 1'b0;
    logic [3:0] ew_b  = 4'd0;
    logic       rst_c = 1'b1, en_c = 1'b0;
    logic [3:0] ew_c  = 4'd0;

    bch_stim_gen_if #(.DATA_BITS(64), .CODE_BITS(78), .WEIGHT_W(4)) bif_a ();
    bch_stim_gen_if #(.DATA_BITS(64), .CODE_BITS(8),  .WEIGHT_W(4)) bif_b ();
    bch_stim_gen_if #(.DATA_BITS(64), .CODE_BITS(78), .WEIGHT_W(4)) bif_c ();

    bch_stim_gen #(.DATA_BITS(64), .CODE_BITS(78), .WEIGHT_W(4), .SEED(32'h0), .NUM_WORDS(0)) dut_a (
        .clk(clk), .reset(rst_a), .enable(en_a), .err_weight(ew_a), .bus(bif_a)
    );
    bch_stim_gen #(.DATA_BITS(64), .CODE_BITS(8), .WEIGHT_W(4), .SEED(32'h1), .NUM_WORDS(0)) dut_b (
        .clk(clk), .reset(rst_b), .enable(en_b), .err_weight(ew_b), .bus(bif_b)
    );
    bch_stim_gen #(.DATA_BITS(64), .CODE_BITS(78), .WEIGHT_W(4), .SEED(32'h1), .NUM_WORDS(3)) dut_c (
        .clk(clk), .reset(rst_c), .enable(en_c), .err_weight(ew_c), .bus(bif_c)
    );

    task automatic reset_a(input logic [3:0] ew, input logic en, input logic rdy);
        rst_a = 1'b1; ew_a = ew; en_a = en; bif_a.ready = rdy;
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
    endtask

    task automatic test_reset;
        rst_a = 1'b1; en_a = 1'b1; bif_a.ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bif_a.start_out !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", bif_a.start_out); end
        checks++; if (bif_a.data_out !== 64'h0) begin errors++; $display("FAIL reset_data: got %h want 0", bif_a.data_out); end
        checks++; if (bif_a.error_out !== 78'h0) begin errors++; $display("FAIL reset_error: got %h want 0", bif_a.error_out); end
        checks++; if (bif_a.weight_out !== 4'd0) begin errors++; $display("FAIL reset_weight: got %0d want 0", bif_a.weight_out); end
        checks++; if (bif_a.words_sent !== 32'd0) begin errors++; $display("FAIL reset_words: got %0d want 0", bif_a.words_sent); end
        checks++; if (bif_a.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bif_a.done); end
        checks++; if (dut_a.u_lfsr.lfsr_q !== 32'h1) begin errors++; $display("FAIL reset_lfsr_seed0: got %h want 00000001", dut_a.u_lfsr.lfsr_q); end
    endtask

    task automatic test_first_word;
        reset_a(4'd0, 1'b1, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (bif_a.start_out !== 1'(c == 3)) begin
                errors++; $display("FAIL first_latency c%0d: got %b want %b", c, bif_a.start_out, (c == 3));
            end
        end
        checks++; if (bif_a.data_out !== WORD1) begin errors++; $display("FAIL first_data: got %h want %h", bif_a.data_out, WORD1); end
        checks++; if (bif_a.error_out !== 78'h0) begin errors++; $display("FAIL first_error: got %h want 0", bif_a.error_out); end
        checks++; if (bif_a.weight_out !== 4'd0) begin errors++; $display("FAIL first_weight: got %0d want 0", bif_a.weight_out); end
    endtask

    task automatic test_back_to_back;
        for (int c = 4; c <= 6; c++) begin
            @(posedge clk); #1;
            checks++;
            if (bif_a.start_out !== 1'(c == 6)) begin
                errors++; $display("FAIL b2b_latency c%0d: got %b want %b", c, bif_a.start_out, (c == 6));
            end
            if (c == 4) begin
                checks++; if (bif_a.words_sent !== 32'd1) begin errors++; $display("FAIL b2b_words1: got %0d want 1", bif_a.words_sent); end
            end
        end
        checks++; if (bif_a.data_out !== WORD2) begin errors++; $display("FAIL b2b_data: got %h want %h", bif_a.data_out, WORD2); end
        en_a = 1'b0;
        @(posedge clk); #1;
        checks++; if (bif_a.words_sent !== 32'd2) begin errors++; $display("FAIL b2b_words2: got %0d want 2", bif_a.words_sent); end
        checks++; if (bif_a.start_out !== 1'b0) begin errors++; $display("FAIL b2b_idle_start: got %b want 0", bif_a.start_out); end
    endtask

    task automatic test_weight3;
        int lat;
`ifdef BCH_STIM_BURST_EN
        lat = 4;
`else
        lat = 6;
`endif
        reset_a(4'd3, 1'b1, 1'b1);
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk); #1;
            checks++;
            if (bif_a.start_out !== 1'(c == lat)) begin
                errors++; $display("FAIL w3_latency c%0d: got %b want %b", c, bif_a.start_out, (c == lat));
            end
        end
        en_a = 1'b0;
        checks++; if (bif_a.error_out !== 78'hE) begin errors++; $display("FAIL w3_error: got %h want e", bif_a.error_out); end
        checks++; if (bif_a.weight_out !== 4'd3) begin errors++; $display("FAIL w3_weight: got %0d want 3", bif_a.weight_out); end
        checks++; if (bif_a.data_out !== WORD1) begin errors++; $display("FAIL w3_data: got %h want %h", bif_a.data_out, WORD1); end
    endtask

    task automatic test_reset_mid_place;
        reset_a(4'd3, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b1;
        @(posedge clk); #1;
        checks++; if (bif_a.start_out !== 1'b0) begin errors++; $display("FAIL midplace_start: got %b want 0", bif_a.start_out); end
        checks++; if (dut_a.u_lfsr.lfsr_q !== 32'h1) begin errors++; $display("FAIL midplace_lfsr: got %h want 00000001", dut_a.u_lfsr.lfsr_q); end
        checks++; if (bif_a.error_out !== 78'h0) begin errors++; $display("FAIL midplace_error: got %h want 0", bif_a.error_out); end
        rst_a = 1'b0; en_a = 1'b0;
    endtask

    task automatic test_stall;
        int n;
        logic [77:0] e_cap;
        reset_a(4'd2, 1'b1, 1'b0);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!bif_a.start_out && n < 200);
        checks++; if (bif_a.start_out !== 1'b1) begin errors++; $display("FAIL stall_timeout: start_out %b after %0d cycles want 1", bif_a.start_out, n); end
        en_a = 1'b0;
        e_cap = bif_a.error_out;
        checks++; if ($countones(e_cap) != 2) begin errors++; $display("FAIL stall_popcount: got %0d want 2", $countones(e_cap)); end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++; if (bif_a.start_out !== 1'b1) begin errors++; $display("FAIL stall_start c%0d: got %b want 1", i, bif_a.start_out); end
            checks++; if (bif_a.data_out !== WORD1) begin errors++; $display("FAIL stall_data c%0d: got %h want %h", i, bif_a.data_out, WORD1); end
            checks++; if (bif_a.error_out !== e_cap) begin errors++; $display("FAIL stall_error c%0d: got %h want %h", i, bif_a.error_out, e_cap); end
            checks++; if (bif_a.words_sent !== 32'd0) begin errors++; $display("FAIL stall_words c%0d: got %0d want 0", i, bif_a.words_sent); end
        end
        bif_a.ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (bif_a.words_sent !== 32'd1) begin errors++; $display("FAIL stall_accept_words: got %0d want 1", bif_a.words_sent); end
        checks++; if (bif_a.start_out !== 1'b0) begin errors++; $display("FAIL stall_accept_start: got %b want 0", bif_a.start_out); end
        bif_a.ready = 1'b0;
    endtask

    task automatic test_weight5_bulk;
        int seen;
        int cyc;
        int lo;
        logic [77:0] m;
        reset_a(4'd5, 1'b1, 1'b1);
        seen = 0;
        cyc  = 0;
        while (seen < 1000 && cyc < 30000) begin
            @(posedge clk); #1; cyc++;
            if (bif_a.start_out) begin
                seen++;
                if (seen == 1000) en_a = 1'b0;
                checks++; if ($countones(bif_a.error_out) != 5) begin errors++; $display("FAIL w5_popcount word%0d: got %0d want 5", seen, $countones(bif_a.error_out)); end
                checks++; if (bif_a.weight_out !== 4'd5) begin errors++; $display("FAIL w5_weight word%0d: got %0d want 5", seen, bif_a.weight_out); end
`ifdef BCH_STIM_BURST_EN
                lo = 0;
                for (int i = 77; i >= 0; i--) if (bif_a.error_out[i]) lo = i;
                m = ((78'(1) << 5) - 78'(1)) << lo;
                checks++; if (bif_a.error_out !== m) begin errors++; $display("FAIL w5_burst word%0d: got %h want %h", seen, bif_a.error_out, m); end
`endif
            end
        end
        checks++; if (seen != 1000) begin errors++; $display("FAIL w5_timeout: got %0d words want 1000", seen); end
        @(posedge clk); #1;
        checks++; if (bif_a.words_sent !== 32'd1000) begin errors++; $display("FAIL w5_words: got %0d want 1000", bif_a.words_sent); end
    endtask

    task automatic test_clamp;
        int n;
        rst_b = 1'b1; ew_b = 4'd15; en_b = 1'b1; bif_b.ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!bif_b.start_out && n < 500);
        en_b = 1'b0;
        checks++; if (bif_b.start_out !== 1'b1) begin errors++; $display("FAIL clamp_timeout: start_out %b after %0d cycles want 1", bif_b.start_out, n); end
        checks++; if (bif_b.weight_out !== 4'd8) begin errors++; $display("FAIL clamp_weight: got %0d want 8", bif_b.weight_out); end
        checks++; if (bif_b.error_out !== 8'hFF) begin errors++; $display("FAIL clamp_error: got %h want ff", bif_b.error_out); end
        checks++; if (bif_b.data_out !== WORD1) begin errors++; $display("FAIL clamp_data: got %h want %h", bif_b.data_out, WORD1); end
    endtask

    task automatic test_num_words;
        rst_c = 1'b1; ew_c = 4'd0; en_c = 1'b1; bif_c.ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_c = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if (bif_c.start_out !== 1'(c == 3 || c == 6 || c == 9)) begin
                errors++; $display("FAIL nw_start c%0d: got %b want %b", c, bif_c.start_out, (c == 3 || c == 6 || c == 9));
            end
            checks++;
            if (bif_c.done !== 1'(c == 10)) begin
                errors++; $display("FAIL nw_done c%0d: got %b want %b", c, bif_c.done, (c == 10));
            end
        end
        checks++; if (bif_c.words_sent !== 32'd3) begin errors++; $display("FAIL nw_words: got %0d want 3", bif_c.words_sent); end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++; if (bif_c.start_out !== 1'b0) begin errors++; $display("FAIL nw_after_start c%0d: got %b want 0", i, bif_c.start_out); end
            checks++; if (bif_c.done !== 1'b1) begin errors++; $display("FAIL nw_after_done c%0d: got %b want 1", i, bif_c.done); end
        end
        rst_c = 1'b1;
        @(posedge clk); #1;
        checks++; if (bif_c.done !== 1'b0) begin errors++; $display("FAIL nw_reset_done: got %b want 0", bif_c.done); end
        checks++; if (bif_c.words_sent !== 32'd0) begin errors++; $display("FAIL nw_reset_words: got %0d want 0", bif_c.words_sent); end
        rst_c = 1'b0; en_c = 1'b0;
    endtask

    initial begin
        bif_a.ready = 1'b0;
        bif_b.ready = 1'b0;
        bif_c.ready = 1'b0;
        @(posedge clk); #1;
        test_reset;
        test_first_word;
        test_back_to_back;
        test_weight3;
        test_reset_mid_place;
        test_stall;
        test_weight5_bulk;
        test_clamp;
        test_num_words;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
